// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter slice: ALUControl opcodes, flag bit
// positions and the arbiter FSM state type.
package alu_pkg;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_XOR = 3'd4;
    localparam logic [2:0] ALU_SLL = 3'd5;
    localparam logic [2:0] ALU_SRL = 3'd6;
    localparam logic [2:0] ALU_SRA = 3'd7;

    localparam int FLAG_C = 3;
    localparam int FLAG_V = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_Z = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// Combinational two-way round-robin grant: a lone requester always wins,
// a tie goes to the requester that did not win last time.
module rr_arb2
    import alu_pkg::*;
(
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic [1:0] grant,
    output logic       grant_id
);

    always_comb begin
        grant_id = 1'b0;
        if (valid == 2'b11) begin
            grant_id = ~last_grant;
        end else if (valid[1]) begin
            grant_id = 1'b1;
        end
        grant = 2'b00;
        if (valid != 2'b00) begin
            grant[grant_id] = 1'b1;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external combinational ALU between two valid/ready requesters:
// grant, register operands, capture result and flags, return a tagged response.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [2:0]   req0_op,
    input  logic [1:0]   req0_amt,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [2:0]   req1_op,
    input  logic [1:0]   req1_amt,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    output logic [2:0]   alu_ctrl,
    output logic [1:0]   alu_amt,
    input  logic [W-1:0] alu_result,
    input  logic [3:0]   alu_flags,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_id,
    output logic [W-1:0] rsp_result,
    output logic [3:0]   rsp_flags,
    output logic         busy
);

    state_t     state;
    logic       last_grant;
    logic [1:0] grant;
    logic       grant_id;

    rr_arb2 u_arb (
        .valid      ({req1_valid, req0_valid}),
        .last_grant (last_grant),
        .grant      (grant),
        .grant_id   (grant_id)
    );

    // Ready is only offered while idle, so a request can never be accepted mid-command.
    assign req0_ready = (state == IDLE) && grant[0];
    assign req1_ready = (state == IDLE) && grant[1];
    assign busy       = (state != IDLE);
    assign rsp_valid  = (state == RESP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_ctrl   <= '0;
            alu_amt    <= '0;
            rsp_id     <= 1'b0;
            rsp_result <= '0;
            rsp_flags  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req0_valid || req1_valid) begin
                        alu_a      <= grant_id ? req1_a   : req0_a;
                        alu_b      <= grant_id ? req1_b   : req0_b;
                        alu_ctrl   <= grant_id ? req1_op  : req0_op;
                        alu_amt    <= grant_id ? req1_amt : req0_amt;
                        rsp_id     <= grant_id;
                        last_grant <= grant_id;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_result <= alu_result;
                    rsp_flags  <= alu_flags;
                    state      <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomised self-checking bench for alu_arbiter, with a behavioural ALU stub
// and a round-robin reference model.
module tb_alu_arbiter;
    import alu_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0_valid, req0_ready, req1_valid, req1_ready;
    logic [2:0] req0_op, req1_op, alu_ctrl;
    logic [1:0] req0_amt, req1_amt, alu_amt;
    logic [7:0] req0_a, req0_b, req1_a, req1_b, alu_a, alu_b, alu_result, rsp_result;
    logic [3:0] alu_flags, rsp_flags;
    logic       rsp_valid, rsp_ready, rsp_id, busy;

    logic [2:0] p_op  [2];
    logic [1:0] p_amt [2];
    logic [7:0] p_a   [2];
    logic [7:0] p_b   [2];

    int   checks = 0;
    int   errors = 0;
    logic model_last;

    assign req0_op = p_op[0];  assign req0_amt = p_amt[0];
    assign req0_a  = p_a[0];   assign req0_b   = p_b[0];
    assign req1_op = p_op[1];  assign req1_amt = p_amt[1];
    assign req1_a  = p_a[1];   assign req1_b   = p_b[1];

    always #5 clk = ~clk;

    alu_arbiter #(.W(8)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_amt(req0_amt), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_amt(req1_amt), .req1_a(req1_a), .req1_b(req1_b),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_amt(alu_amt),
        .alu_result(alu_result), .alu_flags(alu_flags),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags), .busy(busy)
    );

    // Behavioural ALU: returns {flags, result} with flags in C,V,N,Z order.
    function automatic logic [11:0] alu_ref(input logic [2:0] op, input logic [1:0] amt,
                                            input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        logic [7:0] r;
        logic [3:0] f;
        logic       c, v;
        s = '0; r = '0; f = '0; c = 1'b0; v = 1'b0;
        case (op)
            ALU_ADD: begin
                s = {1'b0, a} + {1'b0, b}; r = s[7:0]; c = s[8];
                v = (a[7] == b[7]) && (r[7] != a[7]);
            end
            ALU_SUB: begin
                s = {1'b0, a} - {1'b0, b}; r = s[7:0]; c = ~s[8];
                v = (a[7] != b[7]) && (r[7] != a[7]);
            end
            ALU_AND: r = a & b;
            ALU_OR:  r = a | b;
            ALU_XOR: r = a ^ b;
            ALU_SLL: r = a << amt;
            ALU_SRL: r = a >> amt;
            default: r = $unsigned($signed(a) >>> amt);
        endcase
        f[FLAG_C] = c;
        f[FLAG_V] = v;
        f[FLAG_N] = r[7];
        f[FLAG_Z] = (r == 8'h00);
        return {f, r};
    endfunction

    always_comb {alu_flags, alu_result} = alu_ref(alu_ctrl, alu_amt, alu_a, alu_b);

    function automatic logic [37:0] outs();
        return {req0_ready, req1_ready, alu_a, alu_b, alu_ctrl, alu_amt,
                rsp_valid, rsp_id, rsp_result, rsp_flags, busy};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic randomize_req(input int r);
        p_op[r]  = 3'($urandom_range(0, 7));
        p_amt[r] = 2'($urandom_range(0, 3));
        p_a[r]   = 8'($urandom);
        p_b[r]   = 8'($urandom);
    endtask

    // Waits (bounded) for a response, handshakes it and reports what was seen.
    task automatic collect(input int budget, output bit got, output logic rid,
                           output logic [11:0] rv);
        got = 1'b0; rid = 1'b0; rv = '0;
        rsp_ready = 1'b1;
        for (int i = 0; i < budget && !got; i++) begin
            if (rsp_valid) begin
                got = 1'b1; rid = rsp_id; rv = {rsp_flags, rsp_result};
            end
            step();
        end
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
        for (int r = 0; r < 2; r++) randomize_req(r);
        #2;
        checks++;
        if (outs() !== 38'd0) begin
            errors++; $display("[TB] FAIL reset_values got %h expected 0", outs());
        end
        step();
        checks++;
        if (outs() !== 38'd0) begin
            errors++; $display("[TB] FAIL reset_held got %h expected 0", outs());
        end
        @(negedge clk); rst = 1'b0;
        step();
        model_last = 1'b1;
    endtask

    task automatic test_tie();
        logic [11:0] exp_rv;
        logic        k_id;
        req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            k_id = (k % 2 == 1);
            #1;
            checks++;
            if ({req1_ready, req0_ready} !== (k_id ? 2'b10 : 2'b01)) begin
                errors++;
                $display("[TB] FAIL tie_grant_%0d got %b expected %b", k,
                         {req1_ready, req0_ready}, k_id ? 2'b10 : 2'b01);
            end
            exp_rv = alu_ref(p_op[k_id], p_amt[k_id], p_a[k_id], p_b[k_id]);
            step();
            model_last = k_id;
            randomize_req(int'(k_id));
            checks++;
            if (rsp_valid !== 1'b0 || busy !== 1'b1) begin
                errors++; $display("[TB] FAIL tie_exec_%0d got valid=%b busy=%b expected 0 1", k, rsp_valid, busy);
            end
            step();
            checks++;
            if ({rsp_valid, rsp_id, rsp_flags, rsp_result} !== {1'b1, k_id, exp_rv}) begin
                errors++;
                $display("[TB] FAIL tie_rsp_%0d got %h expected %h", k,
                         {rsp_valid, rsp_id, rsp_flags, rsp_result}, {1'b1, k_id, exp_rv});
            end
            step();
        end
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
    endtask

    task automatic test_single();
        p_op[0] = ALU_ADD; p_amt[0] = 2'd0; p_a[0] = 8'h0F; p_b[0] = 8'h01;
        req0_valid = 1'b1;
        #1;
        checks++;
        if ({req1_ready, req0_ready} !== 2'b01) begin
            errors++; $display("[TB] FAIL single_ready got %b expected 01", {req1_ready, req0_ready});
        end
        step();
        req0_valid = 1'b0;
        model_last = 1'b0;
        checks++;
        if ({rsp_valid, busy, alu_ctrl, alu_a, alu_b} !== {1'b0, 1'b1, ALU_ADD, 8'h0F, 8'h01}) begin
            errors++;
            $display("[TB] FAIL single_exec got %h expected %h", {rsp_valid, busy, alu_ctrl, alu_a, alu_b},
                     {1'b0, 1'b1, ALU_ADD, 8'h0F, 8'h01});
        end
        step();
        checks++;
        if ({rsp_valid, rsp_id, rsp_result, rsp_flags} !== {1'b1, 1'b0, 8'h10, 4'b0000}) begin
            errors++;
            $display("[TB] FAIL single_rsp got %h expected %h",
                     {rsp_valid, rsp_id, rsp_result, rsp_flags}, {1'b1, 1'b0, 8'h10, 4'b0000});
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        checks++;
        if ({rsp_valid, busy} !== 2'b00) begin
            errors++; $display("[TB] FAIL single_done got %b expected 00", {rsp_valid, busy});
        end
    endtask

    task automatic test_backpressure();
        logic [12:0] snap, exp_snap;
        logic [11:0] rv;
        logic        rid;
        bit          got;
        randomize_req(1);
        req1_valid = 1'b1;
        exp_snap = {1'b1, alu_ref(p_op[1], p_amt[1], p_a[1], p_b[1])};
        step();
        req1_valid = 1'b0;
        model_last = 1'b1;
        step();
        snap = {rsp_id, rsp_flags, rsp_result};
        checks++;
        if (snap !== exp_snap) begin
            errors++; $display("[TB] FAIL bp_rsp got %h expected %h", snap, exp_snap);
        end
        randomize_req(0); randomize_req(1);
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if ({rsp_valid, rsp_id, rsp_flags, rsp_result, req1_ready, req0_ready} !== {1'b1, snap, 2'b00}) begin
                errors++;
                $display("[TB] FAIL bp_hold_%0d got %h expected %h", i,
                         {rsp_valid, rsp_id, rsp_flags, rsp_result, req1_ready, req0_ready}, {1'b1, snap, 2'b00});
            end
            step();
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        checks++;
        if ({busy, rsp_valid, req1_ready, req0_ready} !== 4'b0001) begin
            errors++;
            $display("[TB] FAIL bp_release got %b expected 0001", {busy, rsp_valid, req1_ready, req0_ready});
        end
        step();
        req0_valid = 1'b0;
        model_last = 1'b0;
        checks++;
        if ({busy, alu_ctrl, alu_amt, alu_a, alu_b} !== {1'b1, p_op[0], p_amt[0], p_a[0], p_b[0]}) begin
            errors++;
            $display("[TB] FAIL bp_grant got %h expected %h", {busy, alu_ctrl, alu_amt, alu_a, alu_b},
                     {1'b1, p_op[0], p_amt[0], p_a[0], p_b[0]});
        end
        collect(6, got, rid, rv);
        checks++;
        if ({got, rid, rv} !== {1'b1, 1'b0, alu_ref(p_op[0], p_amt[0], p_a[0], p_b[0])}) begin
            errors++; $display("[TB] FAIL bp_rsp0 got %h expected %h", {got, rid, rv},
                               {1'b1, 1'b0, alu_ref(p_op[0], p_amt[0], p_a[0], p_b[0])});
        end
        step();
        req1_valid = 1'b0;
        model_last = 1'b1;
        collect(6, got, rid, rv);
        checks++;
        if ({got, rid, rv} !== {1'b1, 1'b1, alu_ref(p_op[1], p_amt[1], p_a[1], p_b[1])}) begin
            errors++; $display("[TB] FAIL bp_rsp1 got %h expected %h", {got, rid, rv},
                               {1'b1, 1'b1, alu_ref(p_op[1], p_amt[1], p_a[1], p_b[1])});
        end
    endtask

    task automatic test_flags();
        logic [11:0] rv;
        logic        rid;
        bit          got;
        p_op[1] = ALU_ADD; p_amt[1] = 2'd0; p_a[1] = 8'hFF; p_b[1] = 8'h01;
        req1_valid = 1'b1;
        step();
        req1_valid = 1'b0;
        model_last = 1'b1;
        collect(6, got, rid, rv);
        checks++;
        if ({got, rid, rv} !== {1'b1, 1'b1, 4'b1001, 8'h00}) begin
            errors++; $display("[TB] FAIL flags_carry_zero got %h expected %h", {got, rid, rv},
                               {1'b1, 1'b1, 4'b1001, 8'h00});
        end
    endtask

    task automatic test_reset_mid();
        bit          seen;
        logic [11:0] rv;
        logic        rid;
        bit          got;
        randomize_req(0);
        req0_valid = 1'b1;
        step();
        req0_valid = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if (outs() !== 38'd0) begin
            errors++; $display("[TB] FAIL midreset_values got %h expected 0", outs());
        end
        step();
        @(negedge clk); rst = 1'b0;
        step();
        model_last = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (rsp_valid || busy) seen = 1'b1;
            step();
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++; $display("[TB] FAIL midreset_no_rsp got %b expected 0", seen);
        end
        randomize_req(0); randomize_req(1);
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        checks++;
        if ({req1_ready, req0_ready} !== 2'b01) begin
            errors++; $display("[TB] FAIL midreset_tie got %b expected 01", {req1_ready, req0_ready});
        end
        step();
        req0_valid = 1'b0;
        collect(6, got, rid, rv);
        step();
        req1_valid = 1'b0;
        collect(6, got, rid, rv);
        checks++;
        if ({got, rid, rv} !== {1'b1, 1'b1, alu_ref(p_op[1], p_amt[1], p_a[1], p_b[1])}) begin
            errors++; $display("[TB] FAIL midreset_second got %h expected %h", {got, rid, rv},
                               {1'b1, 1'b1, alu_ref(p_op[1], p_amt[1], p_a[1], p_b[1])});
        end
        model_last = 1'b1;
    endtask

    task automatic test_single_repeat();
        logic [20:0] saved;
        rsp_ready = 1'b1;
        randomize_req(1);
        req1_valid = 1'b1;
        for (int n = 0; n < 3; n++) begin
            #1;
            checks++;
            if ({req1_ready, req0_ready} !== 2'b10) begin
                errors++; $display("[TB] FAIL repeat_ready_%0d got %b expected 10", n, {req1_ready, req0_ready});
            end
            saved = {p_op[1], p_amt[1], p_a[1], p_b[1]};
            step();
            randomize_req(1);
            checks++;
            if ({alu_ctrl, alu_amt, alu_a, alu_b} !== saved) begin
                errors++; $display("[TB] FAIL repeat_alu_%0d got %h expected %h", n,
                                   {alu_ctrl, alu_amt, alu_a, alu_b}, saved);
            end
            step();
            checks++;
            if ({rsp_valid, rsp_id, rsp_flags, rsp_result, alu_ctrl, alu_amt, alu_a, alu_b} !==
                {1'b1, 1'b1, alu_ref(saved[20:18], saved[17:16], saved[15:8], saved[7:0]), saved}) begin
                errors++; $display("[TB] FAIL repeat_rsp_%0d got %h expected %h", n,
                    {rsp_valid, rsp_id, rsp_flags, rsp_result, alu_ctrl, alu_amt, alu_a, alu_b},
                    {1'b1, 1'b1, alu_ref(saved[20:18], saved[17:16], saved[15:8], saved[7:0]), saved});
            end
            step();
            checks++;
            if ({busy, alu_ctrl, alu_amt, alu_a, alu_b} !== {1'b0, saved}) begin
                errors++; $display("[TB] FAIL repeat_hold_%0d got %h expected %h", n,
                                   {busy, alu_ctrl, alu_amt, alu_a, alu_b}, {1'b0, saved});
            end
        end
        req1_valid = 1'b0; rsp_ready = 1'b0;
        model_last = 1'b1;
    endtask

    task automatic test_random();
        logic [1:0]  v;
        logic        exp_id;
        logic [11:0] exp_rv, rv;
        logic [20:0] prev;
        logic        rid;
        bit          got;
        for (int it = 0; it < 30; it++) begin
            if (!req0_valid && $urandom_range(0, 1) == 1) begin randomize_req(0); req0_valid = 1'b1; end
            if (!req1_valid && $urandom_range(0, 1) == 1) begin randomize_req(1); req1_valid = 1'b1; end
            v = {req1_valid, req0_valid};
            #1;
            if (v == 2'b00) begin
                prev = {alu_ctrl, alu_amt, alu_a, alu_b};
                step();
                checks++;
                if ({busy, alu_ctrl, alu_amt, alu_a, alu_b} !== {1'b0, prev}) begin
                    errors++; $display("[TB] FAIL rand_idle_%0d got %h expected %h", it,
                                       {busy, alu_ctrl, alu_amt, alu_a, alu_b}, {1'b0, prev});
                end
            end else begin
                exp_id = (v == 2'b11) ? ~model_last : v[1];
                exp_rv = alu_ref(p_op[exp_id], p_amt[exp_id], p_a[exp_id], p_b[exp_id]);
                checks++;
                if ({req1_ready, req0_ready} !== (exp_id ? 2'b10 : 2'b01)) begin
                    errors++; $display("[TB] FAIL rand_grant_%0d got %b expected %b", it,
                                       {req1_ready, req0_ready}, exp_id ? 2'b10 : 2'b01);
                end
                step();
                model_last = exp_id;
                if (exp_id) req1_valid = 1'b0; else req0_valid = 1'b0;
                for (int d = 0; d < int'($urandom_range(0, 3)); d++) step();
                collect(8, got, rid, rv);
                checks++;
                if ({got, rid, rv} !== {1'b1, exp_id, exp_rv}) begin
                    errors++; $display("[TB] FAIL rand_rsp_%0d got %h expected %h", it,
                                       {got, rid, rv}, {1'b1, exp_id, exp_rv});
                end
            end
        end
        for (int k = 0; k < 2; k++) begin
            if (req0_valid || req1_valid) begin
                exp_id = (req0_valid && req1_valid) ? ~model_last : req1_valid;
                exp_rv = alu_ref(p_op[exp_id], p_amt[exp_id], p_a[exp_id], p_b[exp_id]);
                step();
                model_last = exp_id;
                if (exp_id) req1_valid = 1'b0; else req0_valid = 1'b0;
                collect(8, got, rid, rv);
                checks++;
                if ({got, rid, rv} !== {1'b1, exp_id, exp_rv}) begin
                    errors++; $display("[TB] FAIL rand_drain_%0d got %h expected %h", k,
                                       {got, rid, rv}, {1'b1, exp_id, exp_rv});
                end
            end
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        $display("[TB] alu_arbiter bench start");
        test_reset();
        test_tie();
        test_single();
        test_backpressure();
        test_flags();
        test_reset_mid();
        test_single_repeat();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
